t1_reg_bank: RTL and testbench
==============================

Name: t1_reg_bank

Overview:
- Parametrised successor to the single 16-bit active-low-write register.
- Holds DEPTH entries of WIDTH bits, with one write port and two combinational read ports.
- Entry PC_IDX doubles as a program counter and has its own increment strobe.
- A processor-reset request starts a sequenced clear engine that zeroes the bank one entry per cycle. It sits in the datapath as the architectural register file of the multicycle core.

Parameters:
- WIDTH, 16, data width of each entry.
- DEPTH, 8, number of entries; must satisfy 2 <= DEPTH <= 2^ADDR_W.
- ADDR_W, 3, width of every address port.
- PC_IDX, 7, index of the program-counter entry; must be < DEPTH.

Ports:
- clk  in  1  clock; all state updates occur on the falling edge.
- reset  in  1  asynchronous, active-low; clears the whole block immediately.
- proc_rst  in  1  synchronous, active-low; requests a sequenced clear of the bank.
- write  in  1  active-low write enable.
- wr_addr  in  ADDR_W  write index.
- wr_data  in  WIDTH  write data.
- pc_inc  in  1  active-low; increments entry PC_IDX by 1.
- rd_addr_a  in  ADDR_W  read index A.
- rd_data_a  out  WIDTH  read data A, combinational.
- rd_addr_b  in  ADDR_W  read index B.
- rd_data_b  out  WIDTH  read data B, combinational.
- pc_out  out  WIDTH  current contents of entry PC_IDX.
- busy  out  1  high while the clear sweep runs.
- sweep_done  out  1  one-cycle pulse after the sweep completes.

Behaviour:
- Asynchronous reset (reset=0):
  - all entries go to 0; FSM goes to IDLE; clear pointer = 0.
  - busy=0, sweep_done=0; no clock edge required.
  - reset dominates every other input, including mid-sweep.
- FSM states: IDLE, CLEAR, DONE. All transitions are sampled on the falling edge of clk.
  - IDLE: proc_rst=0 -> CLEAR with ptr=0. Otherwise stay in IDLE.
  - CLEAR:
    - entry[ptr] <= 0, ptr <= ptr+1.
    - Entering CLEAR with ptr=0: the first falling edge in CLEAR zeroes entry 0.
    - On the edge that clears entry DEPTH-1 -> DONE.
    - proc_rst=0 while in CLEAR restarts the sweep: ptr <= 0, entry 0 is cleared on that edge, and the FSM stays in CLEAR.
    - The sweep takes exactly DEPTH falling edges after entry.
  - DONE: lasts one cycle, then -> IDLE. proc_rst=0 in DONE -> CLEAR with ptr=0.
- Status outputs (registered from state):
  - busy=1 exactly while the state is CLEAR.
  - sweep_done=1 exactly while the state is DONE.
- Writes (IDLE or DONE only):
  - write=0 and wr_addr<DEPTH -> entry[wr_addr] <= wr_data on the falling edge.
  - wr_addr>=DEPTH -> write ignored.
  - write=1 -> entry holds its value.
  - In CLEAR, write and pc_inc are ignored; the clear engine has priority.
- PC increment (IDLE or DONE only):
  - pc_inc=0 -> entry[PC_IDX] <= entry[PC_IDX]+1, modulo 2^WIDTH (0xFFFF wraps to 0x0000 at WIDTH=16).
  - write=0 with wr_addr=PC_IDX in the same cycle as pc_inc=0 -> the write wins and the increment is dropped.
- Reads (combinational):
  - rd_data_x = entry[rd_addr_x].
  - rd_addr_x>=DEPTH -> rd_data_x = 0.
  - Write-through bypass: when write=0, the FSM is not in CLEAR, wr_addr<DEPTH and wr_addr==rd_addr_x, then rd_data_x = wr_data. This applies to both ports independently.
  - No bypass for pc_inc: reads show the pre-increment value until the edge.
  - In CLEAR, reads return current storage, which is partially cleared.
- pc_out = entry[PC_IDX], raw storage with no bypass.
- No other state exists. All outputs are deterministic after reset.

Test Plan:
- Reset: assert reset=0 mid-cycle with entries loaded -> all rd_data, pc_out = 0 immediately; busy=0, sweep_done=0.
- Write/read: write 0x1234 to idx 3 and 0xBEEF to idx 5; read A=3, B=5 -> 0x1234/0xBEEF. With write=0, wr_addr=2, wr_data=0xAAAA and rd_addr_a=2 -> rd_data_a=0xAAAA before the edge (bypass). wr_addr=9 with DEPTH=8 -> no entry changes; read of idx 9 = 0.
- PC: load PC=0xFFFE, pulse pc_inc=0 for 3 edges -> pc_out 0xFFFF, 0x0000, 0x0001. Simultaneous write 0x0040 to idx 7 and pc_inc=0 -> pc_out=0x0040.
- Sweep: fill all 8 entries with nonzero values, pulse proc_rst=0 for one edge -> busy=1 for 8 edges and entry k reads 0 after edge k+1 (edges numbered from the first edge in CLEAR). A write of 0x5555 to idx 0 during the sweep is ignored. Then sweep_done=1 for exactly one cycle and busy=0.
- Sweep restart/abort: assert proc_rst=0 again at sweep edge 4 -> ptr restarts at 0, with 8 further edges in CLEAR before DONE. Assert reset=0 at edge 2 of a sweep -> IDLE, all entries 0, busy=0 immediately, no sweep_done pulse.

Source files
------------

// File: rtl/t1_reg_bank.sv
// Parametrised register bank with write-through read bypass, a PC entry with its own
// increment strobe, and a sequenced clear engine. All state changes on the falling clk edge.
module t1_reg_bank #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int PC_IDX = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              proc_rst,
    input  logic              write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pc_inc,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [WIDTH-1:0]  pc_out,
    output logic              busy,
    output logic              sweep_done
);

    localparam int                NSLOT    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W-1:0] clr_idx;
    logic              clearing;
    logic              wr_ok;
    logic              wr_en;

    // Full address space is decoded; slots at or above DEPTH are tied to zero,
    // so out-of-range reads fall out of the plain array lookup.
    logic [WIDTH-1:0]  mem [NSLOT];

    assign clearing = (state_reg == CLEAR);
    assign wr_ok    = (int'(wr_addr) < DEPTH);
    assign wr_en    = !write && wr_ok && !clearing;
    // A restart request inside CLEAR redirects this edge's clear to entry 0.
    assign clr_idx  = proc_rst ? ptr_reg : '0;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (!proc_rst) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                if (!proc_rst) begin
                    ptr_next = '0;
                end else if (ptr_reg == LAST_PTR) begin
                    state_next = DONE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + ADDR_W'(1);
                end
            end
            DONE: begin
                state_next = proc_rst ? IDLE : CLEAR;
                ptr_next   = '0;
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_entry
            if (gi < DEPTH) begin : g_live
                logic [WIDTH-1:0] entry_reg, entry_next;

                // Clear engine beats writes; an explicit write to the PC entry beats pc_inc.
                always_comb begin
                    entry_next = entry_reg;
                    if (clearing) begin
                        if (clr_idx == ADDR_W'(gi))
                            entry_next = '0;
                    end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                        entry_next = wr_data;
                    end else if ((gi == PC_IDX) && !pc_inc) begin
                        entry_next = entry_reg + WIDTH'(1);
                    end
                end

                always_ff @(negedge clk or negedge reset) begin
                    if (!reset)
                        entry_reg <= '0;
                    else
                        entry_reg <= entry_next;
                end

                assign mem[gi] = entry_reg;
            end else begin : g_hole
                assign mem[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if (wr_en && (wr_addr == rd_addr_a))
            rd_data_a = wr_data;
    end

    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_b))
            rd_data_b = wr_data;
    end

    assign pc_out     = mem[PC_IDX];
    assign busy       = clearing;
    assign sweep_done = (state_reg == DONE);

endmodule

// File: tb/tb_t1_reg_bank.sv
// Directed bench for t1_reg_bank: table of write/read/PC vectors, then hand-written
// sequences for reset, the clear sweep, sweep restart and reset mid-sweep.
module tb_t1_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        proc_rst;
    logic        write;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        pc_inc;
    logic [3:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic [15:0] pc_out;
    logic        busy;
    logic        sweep_done;

    int n_cmp = 0;
    int n_bad = 0;

    // ADDR_W=4 so that addresses 8..15 lie outside DEPTH=8.
    t1_reg_bank #(.WIDTH(16), .DEPTH(8), .ADDR_W(4), .PC_IDX(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .proc_rst   (proc_rst),
        .write      (write),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pc_inc     (pc_inc),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .pc_out     (pc_out),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_n;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        inc_n;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] epc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // State advances on the falling edge; everything is driven and sampled 1ns after it.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] fv(input int i);
        return 16'(32'h1111 * (i + 1));
    endfunction

    task automatic fill();
        for (int i = 0; i < 8; i++) begin
            write   = 1'b0;
            wr_addr = 4'(i);
            wr_data = fv(i);
            tick();
        end
        write = 1'b1;
    endtask

    task automatic start_sweep();
        proc_rst = 1'b0;
        tick();
        proc_rst = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{1'b0, 4'd3, 16'h1234, 1'b1, 4'd3, 4'd5,  16'h1234, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'd5, 16'hBEEF, 1'b1, 4'd3, 4'd5,  16'h1234, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b1, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd5,  16'h1234, 16'hBEEF, 16'h0000};
        vecs[3]  = '{1'b0, 4'd2, 16'hAAAA, 1'b1, 4'd2, 4'd2,  16'hAAAA, 16'hAAAA, 16'h0000};
        vecs[4]  = '{1'b0, 4'd9, 16'h7777, 1'b1, 4'd9, 4'd2,  16'h0000, 16'hAAAA, 16'h0000};
        vecs[5]  = '{1'b1, 4'd0, 16'h0000, 1'b1, 4'd1, 4'd15, 16'h0000, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 4'd7, 16'hFFFE, 1'b1, 4'd7, 4'd3,  16'hFFFE, 16'h1234, 16'h0000};
        vecs[7]  = '{1'b1, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd2,  16'hFFFE, 16'hAAAA, 16'hFFFE};
        vecs[8]  = '{1'b1, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd5,  16'hFFFF, 16'hBEEF, 16'hFFFF};
        vecs[9]  = '{1'b1, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd9,  16'h0000, 16'h0000, 16'h0000};
        vecs[10] = '{1'b0, 4'd7, 16'h0040, 1'b0, 4'd7, 4'd3,  16'h0040, 16'h1234, 16'h0001};
        vecs[11] = '{1'b1, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd5,  16'h0040, 16'hBEEF, 16'h0040};
        vecs[12] = '{1'b1, 4'd3, 16'hDEAD, 1'b1, 4'd3, 4'd2,  16'h1234, 16'hAAAA, 16'h0040};
        vecs[13] = '{1'b1, 4'd0, 16'h0000, 1'b1, 4'd3, 4'd0,  16'h1234, 16'h0000, 16'h0040};

        reset     = 1'b0;
        proc_rst  = 1'b1;
        write     = 1'b1;
        wr_addr   = '0;
        wr_data   = '0;
        pc_inc    = 1'b1;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd7;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", sweep_done, 1'b0);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_rd_b", rd_data_b, 16'h0000);
        #4 reset = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            write     = vecs[i].wr_n;
            wr_addr   = vecs[i].wa;
            wr_data   = vecs[i].wd;
            pc_inc    = vecs[i].inc_n;
            rd_addr_a = vecs[i].ra;
            rd_addr_b = vecs[i].rb;
            #1;
            $display("vec %0d: a=%h b=%h pc=%h", i, rd_data_a, rd_data_b, pc_out);
            chk($sformatf("vec%0d_a", i), rd_data_a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), rd_data_b, vecs[i].eb);
            chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].epc);
            tick();
        end
        write  = 1'b1;
        pc_inc = 1'b1;

        // Asynchronous reset in the middle of a cycle with data loaded.
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd3;
        #1;
        $display("async reset: pre a=%h b=%h pc=%h", rd_data_a, rd_data_b, pc_out);
        chk("prereset_a", rd_data_a, 16'hBEEF);
        #2 reset = 1'b0;
        #1;
        $display("async reset: post a=%h b=%h pc=%h", rd_data_a, rd_data_b, pc_out);
        chk("areset_a", rd_data_a, 16'h0000);
        chk("areset_b", rd_data_b, 16'h0000);
        chk("areset_pc", pc_out, 16'h0000);
        chk("areset_busy", busy, 1'b0);
        chk("areset_done", sweep_done, 1'b0);
        #1 reset = 1'b1;
        tick();

        // Full sweep, with an attempted write to entry 0 on every sweep edge.
        fill();
        start_sweep();
        chk("sweep_busy0", busy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            write     = 1'b0;
            wr_addr   = 4'd0;
            wr_data   = 16'h5555;
            rd_addr_a = 4'(k);
            rd_addr_b = 4'd0;
            #1;
            chk($sformatf("sweep%0d_pre", k), rd_data_a, fv(k));
            chk($sformatf("sweep%0d_e0", k), rd_data_b, (k == 0) ? fv(0) : 16'h0000);
            chk($sformatf("sweep%0d_busy", k), busy, 1'b1);
            tick();
            write = 1'b1;
            #1;
            $display("sweep edge %0d: entry%0d=%h busy=%b done=%b", k + 1, k, rd_data_a, busy, sweep_done);
            chk($sformatf("sweep%0d_clr", k), rd_data_a, 16'h0000);
        end
        rd_addr_a = 4'd0;
        #1;
        chk("sweep_done_hi", sweep_done, 1'b1);
        chk("sweep_busy_lo", busy, 1'b0);
        chk("sweep_e0_zero", rd_data_a, 16'h0000);
        tick();
        chk("sweep_done_lo", sweep_done, 1'b0);
        chk("sweep_idle_busy", busy, 1'b0);

        // Restart request on sweep edge 4.
        fill();
        start_sweep();
        tick();
        tick();
        tick();
        proc_rst = 1'b0;
        tick();
        proc_rst  = 1'b1;
        rd_addr_a = 4'd3;
        #1;
        chk("restart_e3_kept", rd_data_a, fv(3));
        chk("restart_busy", busy, 1'b1);
        n = 0;
        while (sweep_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        $display("restart: %0d edges from restart to DONE", n);
        chk("restart_edges", n, 8);
        chk("restart_e3_zero", rd_data_a, 16'h0000);
        tick();
        chk("restart_idle_done", sweep_done, 1'b0);

        // Reset arriving after sweep edge 2.
        fill();
        start_sweep();
        tick();
        tick();
        rd_addr_a = 4'd5;
        #1;
        chk("abort_pre_e5", rd_data_a, fv(5));
        #1 reset = 1'b0;
        #1;
        $display("abort: busy=%b done=%b pc=%h a=%h", busy, sweep_done, pc_out, rd_data_a);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", sweep_done, 1'b0);
        chk("abort_pc", pc_out, 16'h0000);
        chk("abort_e5", rd_data_a, 16'h0000);
        #1 reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("abort_idle%0d_done", k), sweep_done, 1'b0);
            chk($sformatf("abort_idle%0d_busy", k), busy, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
